// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access unit: funct3 size
// encodings, FSM state encoding and the access-size helper.
package dmem_pkg;

  localparam logic [2:0] SIZE_B  = 3'b000;
  localparam logic [2:0] SIZE_H  = 3'b001;
  localparam logic [2:0] SIZE_W  = 3'b010;
  localparam logic [2:0] SIZE_BU = 3'b100;
  localparam logic [2:0] SIZE_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_DONE = 2'd3
  } dmem_state_e;

  // Number of bytes moved by a funct3 size; 0 marks an illegal encoding.
  function automatic logic [2:0] size_bytes(input logic [2:0] size);
    case (size)
      SIZE_B, SIZE_BU: size_bytes = 3'd1;
      SIZE_H, SIZE_HU: size_bytes = 3'd2;
      SIZE_W:          size_bytes = 3'd4;
      default:         size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_access_unit_if.sv
// Word-wide req/ack data-SRAM port. The access unit is the master,
// the SRAM (or its model) is the slave.
interface dmem_access_unit_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    mem_req;
  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;
  logic                    mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for the access unit.
// Store side: byte enables for the first/second word and write data
// rotated so byte 0 lands on lane `offset`.
// Load side: picks n bytes starting at `offset` out of {hi, lo} and
// sign- or zero-extends them.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  offset,
  input  logic        second,       // 1 = second word of a split access
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_data_rot,
  input  logic [31:0] ld_lo,        // word holding the first byte
  input  logic [23:0] ld_hi,        // following word (only 3 bytes can spill)
  output logic [31:0] ld_data
);

  logic [2:0]  nbytes;
  logic [3:0]  lane_base;
  logic [7:0]  lane_mask;
  logic [31:0] ld_shift;
  logic        ld_signed;

  // Byte-enable mask spanning two words; upper nibble belongs to the second word.
  always_comb begin
    nbytes = size_bytes(size);
    case (nbytes)
      3'd1:    lane_base = 4'b0001;
      3'd2:    lane_base = 4'b0011;
      3'd4:    lane_base = 4'b1111;
      default: lane_base = 4'b0000;
    endcase
    lane_mask = {4'b0000, lane_base} << offset;
    st_be     = second ? lane_mask[7:4] : lane_mask[3:0];
  end

  // Rotate store data left by 8*offset; the wrapped low bytes feed the second word.
  always_comb begin
    case (offset)
      2'd0:    st_data_rot = st_data;
      2'd1:    st_data_rot = {st_data[23:0], st_data[31:24]};
      2'd2:    st_data_rot = {st_data[15:0], st_data[31:16]};
      default: st_data_rot = {st_data[7:0],  st_data[31:8]};
    endcase
  end

  // Extract from {hi, lo} >> 8*offset, then truncate and extend.
  always_comb begin
    case (offset)
      2'd0:    ld_shift = ld_lo;
      2'd1:    ld_shift = {ld_hi[7:0],  ld_lo[31:8]};
      2'd2:    ld_shift = {ld_hi[15:0], ld_lo[31:16]};
      default: ld_shift = {ld_hi[23:0], ld_lo[31:24]};
    endcase
    ld_signed = ~size[2];
    case (nbytes)
      3'd1:    ld_data = {{24{ld_signed & ld_shift[7]}},  ld_shift[7:0]};
      3'd2:    ld_data = {{16{ld_signed & ld_shift[15]}}, ld_shift[15:0]};
      default: ld_data = ld_shift;
    endcase
  end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory access unit between the MEM stage and a req/ack word SRAM.
// Holds the core with `stall`, issues byte-lane word transactions and
// returns extended load data with a one-cycle `rsp_valid` pulse.
// Build option: DMEM_MISALIGNED_SPLIT_EN - when defined, accesses that
// cross a word boundary are split into two transactions (ACC0, ACC1);
// when undefined, any access not naturally aligned faults.
module dmem_access_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,        // asynchronous, active low
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_valid,
  output logic                  stall,
  output logic                  fault,
  dmem_access_unit_if.master    mem
);

  dmem_state_e           state_q, state_d;
  logic                  fault_q, fault_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic                  req_any;
  logic                  req_err;
  logic [2:0]            nbytes;
  logic [1:0]            offset;
  logic                  in_second;
  logic                  stall_c;
  logic                  mem_active;
  logic                  acc_done;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [3:0]            lane_be;
  logic [31:0]           lane_wdata;
  logic [31:0]           ld_lo;
  logic [23:0]           ld_hi;
  logic [31:0]           ld_data;

`ifdef DMEM_MISALIGNED_SPLIT_EN
  logic [31:0] word0_q, word0_d;
  logic        split_acc;
`else
  logic [1:0]  align_mask;
  logic        misaligned;
`endif

  assign req_any   = req_read | req_write;
  assign nbytes    = size_bytes(req_size);
  assign offset    = req_addr[1:0];
  assign word_addr = {req_addr[ADDR_WIDTH-1:2], 2'b00};
  assign in_second = (state_q == ST_ACC1);

  // Request legality; alignment only matters when splitting is not built in.
`ifdef DMEM_MISALIGNED_SPLIT_EN
  assign split_acc = ({2'b00, offset} + {1'b0, nbytes}) > 4'd4;
  assign req_err   = (req_read & req_write) | (nbytes == 3'd0) |
                     (req_write & req_size[2]);
`else
  always_comb begin
    case (nbytes)
      3'd4:    align_mask = 2'b11;
      3'd2:    align_mask = 2'b01;
      default: align_mask = 2'b00;
    endcase
    misaligned = |(offset & align_mask);
  end
  assign req_err = (req_read & req_write) | (nbytes == 3'd0) |
                   (req_write & req_size[2]) | misaligned;
`endif

  // Load source words: the first word is held while the second arrives.
`ifdef DMEM_MISALIGNED_SPLIT_EN
  assign ld_lo = in_second ? word0_q : mem.mem_rdata;
  assign ld_hi = in_second ? mem.mem_rdata[23:0] : 24'h0;
`else
  assign ld_lo = mem.mem_rdata;
  assign ld_hi = 24'h0;
`endif

  dmem_lane_align u_lane_align (
    .size        (req_size),
    .offset      (offset),
    .second      (in_second),
    .st_data     (req_wdata),
    .st_be       (lane_be),
    .st_data_rot (lane_wdata),
    .ld_lo       (ld_lo),
    .ld_hi       (ld_hi),
    .ld_data     (ld_data)
  );

  // Next-state, stall and capture logic; mem_ack only matters in ACC states.
  always_comb begin
    state_d     = state_q;
    fault_d     = fault_q;
    rsp_rdata_d = rsp_rdata_q;
`ifdef DMEM_MISALIGNED_SPLIT_EN
    word0_d     = word0_q;
`endif
    stall_c     = 1'b0;
    mem_active  = 1'b0;
    acc_done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          stall_c = 1'b1;
          if (req_err) begin
            state_d     = ST_DONE;
            fault_d     = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = ST_ACC0;
          end
        end
      end
      ST_ACC0: begin
        stall_c    = 1'b1;
        mem_active = 1'b1;
        if (mem.mem_ack) begin
`ifdef DMEM_MISALIGNED_SPLIT_EN
          if (split_acc) begin
            state_d = ST_ACC1;
            word0_d = mem.mem_rdata;
          end else begin
            acc_done = 1'b1;
          end
`else
          acc_done = 1'b1;
`endif
        end
      end
`ifdef DMEM_MISALIGNED_SPLIT_EN
      ST_ACC1: begin
        stall_c    = 1'b1;
        mem_active = 1'b1;
        if (mem.mem_ack) begin
          acc_done = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
        fault_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (acc_done) begin
      state_d     = ST_DONE;
      fault_d     = 1'b0;
      rsp_rdata_d = req_read ? ld_data : '0;
    end
  end

  // State and response registers; reset drops the bus request immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      fault_q     <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef DMEM_MISALIGNED_SPLIT_EN
  // First word of a split load, kept until the second word arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word0_q <= '0;
    end else begin
      word0_q <= word0_d;
    end
  end
`endif

  assign mem.mem_req   = mem_active;
  assign mem.mem_we    = mem_active & req_write;
  assign mem.mem_addr  = !mem_active ? '0 :
                         in_second ? word_addr + ADDR_WIDTH'(4) : word_addr;
  assign mem.mem_be    = mem_active ? lane_be : 4'b0000;
  assign mem.mem_wdata = mem_active ? lane_wdata : '0;

  assign stall     = stall_c & rst;
  assign rsp_valid = (state_q == ST_DONE);
  assign fault     = fault_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit; the SRAM side is driven inline
// by the access task with a programmable ack delay.
module tb_dmem_access_unit;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_read, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [31:0] rsp_rdata;
  logic        rsp_valid, stall, fault;

  int checks   = 0;
  int failures = 0;

  dmem_access_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();

  dmem_access_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_read  (req_read),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_wdata (req_wdata),
    .rsp_rdata (rsp_rdata),
    .rsp_valid (rsp_valid),
    .stall     (stall),
    .fault     (fault),
    .mem       (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observations from the last access
  int          o_stall, o_txn;
  logic        o_valid, o_fault, o_stable, o_timeout, o_done_stall;
  logic [31:0] o_rdata;
  logic [3:0]  o_be   [0:1];
  logic [31:0] o_addr [0:1];
  logic [31:0] o_wdata[0:1];
  logic        o_we   [0:1];

  // Run one access: inputs change at negedge, outputs sampled 1ns later.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wd,
                            input int delay, input logic [31:0] w0, input logic [31:0] w1);
    int wait_c;
    @(negedge clk);
    req_read = rd; req_write = wr; req_addr = addr; req_size = size; req_wdata = wd;
    o_stall = 0; o_txn = 0; o_valid = 0; o_fault = 0; o_rdata = 0;
    o_stable = 1; o_timeout = 1; o_done_stall = 0;
    for (int k = 0; k < 2; k++) begin
      o_be[k] = 0; o_addr[k] = 0; o_wdata[k] = 0; o_we[k] = 0;
    end
    wait_c = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      #1;
      if (stall) o_stall++;
      if (rsp_valid) begin
        o_valid = 1; o_rdata = rsp_rdata; o_fault = fault;
        o_done_stall = stall; o_timeout = 0;
        req_read = 0; req_write = 0;
        break;
      end
      if (mem_if.mem_req) begin
        if (o_txn < 2) begin
          if (wait_c == 0) begin
            o_be[o_txn] = mem_if.mem_be; o_addr[o_txn] = mem_if.mem_addr;
            o_wdata[o_txn] = mem_if.mem_wdata; o_we[o_txn] = mem_if.mem_we;
          end else if (mem_if.mem_be !== o_be[o_txn] || mem_if.mem_addr !== o_addr[o_txn] ||
                       mem_if.mem_wdata !== o_wdata[o_txn] || mem_if.mem_we !== o_we[o_txn]) begin
            o_stable = 0;
          end
        end
        if (wait_c == delay) begin
          mem_if.mem_ack = 1'b1;
          mem_if.mem_rdata = (o_txn == 0) ? w0 : w1;
          o_txn++;
          wait_c = 0;
        end else begin
          wait_c++;
        end
      end
      @(negedge clk);
      mem_if.mem_ack = 1'b0;
      mem_if.mem_rdata = 32'h0;
    end
    if (o_timeout) begin
      req_read = 0; req_write = 0;
    end
    mem_if.mem_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_read = 1'b1; req_write = 1'b0; req_addr = 32'h100; req_size = SIZE_W; req_wdata = 32'h0;
    mem_if.mem_ack = 1'b0; mem_if.mem_rdata = 32'h0;
    @(negedge clk); @(negedge clk); #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (mem_if.mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%b exp=0", mem_if.mem_req); end
    checks++; if (rsp_valid !== 1'b0 || fault !== 1'b0) begin failures++; $display("FAIL reset_valid_fault got=%b%b exp=00", rsp_valid, fault); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=00000000", rsp_rdata); end
    checks++; if ({mem_if.mem_we, mem_if.mem_be, mem_if.mem_addr, mem_if.mem_wdata} !== 69'h0) begin
      failures++; $display("FAIL reset_mem_bus got=%b/%h/%h/%h exp=0", mem_if.mem_we, mem_if.mem_be, mem_if.mem_addr, mem_if.mem_wdata);
    end
    req_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_lw_aligned;
    run_access(1, 0, 32'h100, SIZE_W, 32'h0, 0, 32'hDEADBEEF, 32'h0);
    $display("LW 0x100 -> rdata=%h stall=%0d txn=%0d", o_rdata, o_stall, o_txn);
    checks++; if (o_timeout) begin failures++; $display("FAIL lw_timeout got=no_rsp exp=rsp_valid"); end
    checks++; if (o_stall != 2) begin failures++; $display("FAIL lw_stall got=%0d exp=2", o_stall); end
    checks++; if (o_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_rdata got=%h exp=deadbeef", o_rdata); end
    checks++; if (o_be[0] !== 4'hF || o_addr[0] !== 32'h100 || o_we[0] !== 1'b0) begin
      failures++; $display("FAIL lw_bus got=be%b addr%h we%b exp=be1111 addr00000100 we0", o_be[0], o_addr[0], o_we[0]);
    end
    checks++; if (o_txn != 1 || o_fault !== 1'b0) begin failures++; $display("FAIL lw_txn_fault got=%0d/%b exp=1/0", o_txn, o_fault); end
    checks++; if (o_done_stall !== 1'b0) begin failures++; $display("FAIL lw_done_stall got=%b exp=0", o_done_stall); end
  endtask

  task automatic test_sub_word_loads;
    run_access(1, 0, 32'h103, SIZE_B, 32'h0, 0, 32'h80112233, 32'h0);
    $display("LB 0x103 -> rdata=%h be=%b", o_rdata, o_be[0]);
    checks++; if (o_be[0] !== 4'b1000 || o_addr[0] !== 32'h100) begin failures++; $display("FAIL lb_bus got=be%b addr%h exp=be1000 addr00000100", o_be[0], o_addr[0]); end
    checks++; if (o_rdata !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_rdata got=%h exp=ffffff80", o_rdata); end
    run_access(1, 0, 32'h103, SIZE_BU, 32'h0, 0, 32'h80112233, 32'h0);
    $display("LBU 0x103 -> rdata=%h", o_rdata);
    checks++; if (o_rdata !== 32'h00000080) begin failures++; $display("FAIL lbu_rdata got=%h exp=00000080", o_rdata); end
    run_access(1, 0, 32'h102, SIZE_H, 32'h0, 1, 32'h80112233, 32'h0);
    $display("LH 0x102 -> rdata=%h be=%b", o_rdata, o_be[0]);
    checks++; if (o_rdata !== 32'hFFFF8011 || o_be[0] !== 4'b1100) begin failures++; $display("FAIL lh_rdata got=%h/%b exp=ffff8011/1100", o_rdata, o_be[0]); end
    run_access(1, 0, 32'h102, SIZE_HU, 32'h0, 0, 32'h80112233, 32'h0);
    $display("LHU 0x102 -> rdata=%h", o_rdata);
    checks++; if (o_rdata !== 32'h00008011) begin failures++; $display("FAIL lhu_rdata got=%h exp=00008011", o_rdata); end
  endtask

  task automatic test_stores;
    run_access(0, 1, 32'h102, SIZE_H, 32'h0000ABCD, 3, 32'h0, 32'h0);
    $display("SH 0x102 -> wdata=%h be=%b stall=%0d stable=%b", o_wdata[0], o_be[0], o_stall, o_stable);
    checks++; if (o_wdata[0] !== 32'hABCD0000) begin failures++; $display("FAIL sh_wdata got=%h exp=abcd0000", o_wdata[0]); end
    checks++; if (o_be[0] !== 4'b1100 || o_we[0] !== 1'b1) begin failures++; $display("FAIL sh_be_we got=%b/%b exp=1100/1", o_be[0], o_we[0]); end
    checks++; if (o_stable !== 1'b1) begin failures++; $display("FAIL sh_stable got=%b exp=1", o_stable); end
    checks++; if (o_stall != 5) begin failures++; $display("FAIL sh_stall got=%0d exp=5", o_stall); end
    checks++; if (o_fault !== 1'b0 || o_txn != 1) begin failures++; $display("FAIL sh_fault_txn got=%b/%0d exp=0/1", o_fault, o_txn); end
    run_access(0, 1, 32'h101, SIZE_B, 32'h000000EE, 0, 32'h0, 32'h0);
    $display("SB 0x101 -> wdata=%h be=%b", o_wdata[0], o_be[0]);
    checks++; if (o_wdata[0] !== 32'h0000EE00 || o_be[0] !== 4'b0010) begin failures++; $display("FAIL sb_lanes got=%h/%b exp=0000ee00/0010", o_wdata[0], o_be[0]); end
  endtask

  task automatic test_misaligned;
    run_access(1, 0, 32'h0FE, SIZE_W, 32'h0, 0, 32'h11223344, 32'h55667788);
    $display("LW 0x0FE -> rdata=%h fault=%b txn=%0d stall=%0d", o_rdata, o_fault, o_txn, o_stall);
`ifdef DMEM_MISALIGNED_SPLIT_EN
    checks++; if (o_txn != 2 || o_be[0] !== 4'b1100 || o_be[1] !== 4'b0011) begin
      failures++; $display("FAIL split_be got=%0d/%b/%b exp=2/1100/0011", o_txn, o_be[0], o_be[1]);
    end
    checks++; if (o_addr[0] !== 32'h0FC || o_addr[1] !== 32'h100) begin failures++; $display("FAIL split_addr got=%h/%h exp=000000fc/00000100", o_addr[0], o_addr[1]); end
    checks++; if (o_rdata !== 32'h77881122 || o_fault !== 1'b0) begin failures++; $display("FAIL split_rdata got=%h/%b exp=77881122/0", o_rdata, o_fault); end
    checks++; if (o_stall != 3) begin failures++; $display("FAIL split_stall got=%0d exp=3", o_stall); end
    run_access(1, 0, 32'hFFFFFFFF, SIZE_H, 32'h0, 0, 32'hAA000000, 32'h000000BB);
    $display("LH 0xFFFFFFFF -> rdata=%h addr1=%h", o_rdata, o_addr[1]);
    checks++; if (o_addr[1] !== 32'h0 || o_be[0] !== 4'b1000 || o_be[1] !== 4'b0001) begin
      failures++; $display("FAIL wrap_bus got=%h/%b/%b exp=00000000/1000/0001", o_addr[1], o_be[0], o_be[1]);
    end
    checks++; if (o_rdata !== 32'hFFFFBBAA) begin failures++; $display("FAIL wrap_rdata got=%h exp=ffffbbaa", o_rdata); end
`else
    checks++; if (o_fault !== 1'b1 || o_txn != 0) begin failures++; $display("FAIL misalign_fault got=%b/%0d exp=1/0", o_fault, o_txn); end
    checks++; if (o_rdata !== 32'h0) begin failures++; $display("FAIL misalign_rdata got=%h exp=00000000", o_rdata); end
    checks++; if (o_stall != 1) begin failures++; $display("FAIL misalign_stall got=%0d exp=1", o_stall); end
    run_access(1, 0, 32'h101, SIZE_H, 32'h0, 0, 32'h12345678, 32'h0);
    $display("LH 0x101 -> fault=%b txn=%0d", o_fault, o_txn);
    checks++; if (o_fault !== 1'b1 || o_txn != 0) begin failures++; $display("FAIL lh_misalign got=%b/%0d exp=1/0", o_fault, o_txn); end
`endif
  endtask

  task automatic test_errors;
    run_access(1, 1, 32'h100, SIZE_W, 32'h0, 0, 32'h12345678, 32'h0);
    $display("RD+WR -> fault=%b stall=%0d txn=%0d", o_fault, o_stall, o_txn);
    checks++; if (o_fault !== 1'b1 || o_txn != 0 || o_stall != 1) begin
      failures++; $display("FAIL err_rdwr got=%b/%0d/%0d exp=1/0/1", o_fault, o_txn, o_stall);
    end
    run_access(1, 0, 32'h100, 3'b011, 32'h0, 0, 32'h12345678, 32'h0);
    $display("size 011 -> fault=%b stall=%0d txn=%0d", o_fault, o_stall, o_txn);
    checks++; if (o_fault !== 1'b1 || o_txn != 0 || o_stall != 1) begin
      failures++; $display("FAIL err_size got=%b/%0d/%0d exp=1/0/1", o_fault, o_txn, o_stall);
    end
    run_access(0, 1, 32'h100, SIZE_BU, 32'h55, 0, 32'h0, 32'h0);
    $display("SBU -> fault=%b txn=%0d", o_fault, o_txn);
    checks++; if (o_fault !== 1'b1 || o_txn != 0) begin failures++; $display("FAIL err_sbu got=%b/%0d exp=1/0", o_fault, o_txn); end
    // fault is a pulse: gone once back in IDLE
    @(negedge clk); #1;
    checks++; if (fault !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b%b exp=00", fault, rsp_valid); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    @(negedge clk);
    req_read = 1; req_write = 0; req_addr = 32'h200; req_size = SIZE_W;
    @(negedge clk); #1;
    checks++; if (mem_if.mem_req !== 1'b1) begin failures++; $display("FAIL rstmid_acc0 got=%b exp=1", mem_if.mem_req); end
    rst = 1'b0; #1;
    checks++; if (mem_if.mem_req !== 1'b0 || stall !== 1'b0) begin failures++; $display("FAIL rstmid_drop got=%b/%b exp=0/0", mem_if.mem_req, stall); end
    req_read = 0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); mem_if.mem_ack = 1'b1; mem_if.mem_rdata = 32'h12345678;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1; if (rsp_valid) seen = 1;
      @(negedge clk); mem_if.mem_ack = 1'b0;
    end
    $display("reset mid-access -> late ack rsp_valid seen=%b", seen);
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_late_ack got=%b exp=0", seen); end
    run_access(1, 0, 32'h200, SIZE_W, 32'h0, 0, 32'h0BADCAFE, 32'h0);
    $display("LW 0x200 after reset -> rdata=%h stall=%0d", o_rdata, o_stall);
    checks++; if (o_rdata !== 32'h0BADCAFE || o_stall != 2) begin failures++; $display("FAIL rstmid_recover got=%h/%0d exp=0badcafe/2", o_rdata, o_stall); end
  endtask

  task automatic test_back_to_back;
    run_access(1, 0, 32'h104, SIZE_H, 32'h0, 0, 32'hCAFEF00D, 32'h0);
    $display("LH 0x104 -> rdata=%h", o_rdata);
    checks++; if (o_rdata !== 32'hFFFFF00D) begin failures++; $display("FAIL b2b_first got=%h exp=fffff00d", o_rdata); end
    run_access(0, 1, 32'h108, SIZE_W, 32'h12345678, 1, 32'h0, 32'h0);
    $display("SW 0x108 -> wdata=%h be=%b stall=%0d", o_wdata[0], o_be[0], o_stall);
    checks++; if (o_wdata[0] !== 32'h12345678 || o_be[0] !== 4'hF || o_addr[0] !== 32'h108) begin
      failures++; $display("FAIL b2b_second got=%h/%b/%h exp=12345678/1111/00000108", o_wdata[0], o_be[0], o_addr[0]);
    end
    checks++; if (o_stall != 3) begin failures++; $display("FAIL b2b_stall got=%0d exp=3", o_stall); end
  endtask

  initial begin
    test_reset;
    test_lw_aligned;
    test_sub_word_loads;
    test_stores;
    test_misaligned;
    test_errors;
    test_reset_mid;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
